flit_sink: RTL and testbench
============================

# flit_sink

Receive-side endpoint for the single-port flit stream produced by the characterization muxes. Samples `odata/ovalid/ovch`-style flits, checks HEAD/DATA/TAIL framing per packet, and keeps packet, flit and error counters. Also accumulates payload bit toggles between consecutive valid flits, used as a switching-activity figure for energy characterization. Sits directly on a mux output port in the characterization benches and in post-P&R power runs.

## Interface
- `DATAW` — default 66 — flit width; bits [DATAW-1:DATAW-2] are the type field, bits [DATAW-3:0] are the payload
- `VCHW` — default 2 — virtual-channel field width
- `LENW` — default 8 — width of the per-packet data-flit length counter
- `clk` — input, 1 — clock
- `rst` — input, 1 — reset, synchronous, active-high
- `clr` — input, 1 — synchronous counter/FSM clear
- `idata` — input, DATAW — flit
- `ivalid` — input, 1 — flit valid
- `ivch` — input, VCHW — flit virtual channel
- `pkt_done` — output, 1 — one-cycle pulse when a well-formed packet completes
- `last_len` — output, LENW — data-flit count of the last completed packet
- `last_vch` — output, VCHW — VC of the last completed packet
- `pkt_cnt` — output, 32 — completed packets
- `flit_cnt` — output, 32 — valid flits sampled
- `err_cnt` — output, 16 — framing errors
- `toggle_acc` — output, 32 — accumulated payload Hamming distance

## Operation
- Type encoding: NONE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11.
- A flit is consumed on any rising `clk` with `ivalid`=1. There is no backpressure; the sink always accepts.
- FSM states are IDLE and BODY. Registers `len` (LENW) and `cur_vch` (VCHW).
- IDLE + HEAD:
  - Go to BODY, set `len`=0, set `cur_vch`=`ivch`.
- IDLE + DATA, TAIL or NONE:
  - `err_cnt`+1; stay in IDLE.
- BODY + DATA:
  - `len`+1, saturating at 2^LENW-1.
- BODY + TAIL:
  - Pulse `pkt_done`, `pkt_cnt`+1.
  - Load `last_len`=`len` and `last_vch`=`cur_vch`.
  - Go to IDLE.
- BODY + HEAD:
  - `err_cnt`+1. Restart the packet: `len`=0, `cur_vch`=`ivch`. Stay in BODY.
- BODY + NONE:
  - `err_cnt`+1; abandon the packet and go to IDLE.
- BODY + any flit with `ivch`≠`cur_vch`:
  - `err_cnt`+1. The type is still processed normally, but a TAIL with mismatched VC does not pulse `pkt_done` and does not increment `pkt_cnt`; it goes to IDLE.
- At most one error increment per flit.
- `flit_cnt` increments for every valid flit, including erroneous ones.
- `ivalid`=0 leaves all state unchanged. Gaps mid-packet are legal.
- Counter widths:
  - `pkt_cnt` and `flit_cnt` wrap modulo 2^32.
  - `err_cnt` saturates at 16'hFFFF.
- `clr`:
  - Zeroes all counters, `last_len`, `last_vch`, `len`, the previous-payload register and the first-flag.
  - Forces IDLE.
  - A flit presented in the same cycle is discarded: it is not counted and not checked.
  - `rst` has priority over `clr`.

## Timing
- All outputs are registered. Each output reflects the flit sampled at edge N after edge N.
- `pkt_done` is high for exactly the cycle following the TAIL edge.
- Reset values: `pkt_done`=0, `last_len`=0, `last_vch`=0, all counters=0, `toggle_acc`=0, FSM=IDLE.
- Reset mid-packet drops the packet. No error is counted.
- Back-to-back packets with TAIL at edge N and HEAD at edge N+1 are legal.
- Back-to-back TAIL→TAIL: the second TAIL is an error in IDLE.

## Configuration
- `FLIT_SINK_TOGGLE_EN` defined:
  - Holds the previous valid payload (DATAW-2 bits) and a first-flag.
  - On each valid flit after the first (since reset/clr), adds popcount(payload XOR prev) to `toggle_acc`, saturating at 32'hFFFFFFFF. Then stores the payload.
  - Toggles across NONE flits are included.
  - The update lands in the same registered cycle as the counters.
- Not defined: no toggle logic is built; `toggle_acc` is tied to 0.

## Test plan
- HEAD vc=1, 20 DATA, TAIL vc=1 → `pkt_done` pulses one cycle after TAIL; `last_len`=20, `last_vch`=1, `pkt_cnt`=1, `flit_cnt`=22, `err_cnt`=0.
- 10 packets of 20 DATA, each followed by a 7-cycle `ivalid`=0 gap → `pkt_cnt`=10, `flit_cnt`=220, `err_cnt`=0.
- Framing errors: DATA in IDLE, then HEAD, HEAD, TAIL → `err_cnt`=2, `pkt_cnt`=1, `last_len`=0. Separately, HEAD vc=0 then TAIL vc=2 → `err_cnt`+1, no `pkt_done`.
- Length saturation with LENW=8: 300 DATA between HEAD and TAIL → `last_len`=255.
- Toggles with `FLIT_SINK_TOGGLE_EN` defined: payloads 0, all-ones, all-ones, 64'hF → `toggle_acc`=64+0+60=124. With the macro undefined, `toggle_acc` stays 0.
- `clr` asserted together with a TAIL mid-packet → all counters 0, no `pkt_done`. The next HEAD/DATA/TAIL completes with `last_len`=1.

Source files
------------

// File: rtl/flit_sink.sv
// flit_sink: receive-side endpoint for a single-port flit stream.
// Checks HEAD/DATA/TAIL framing per packet and keeps packet, flit and
// error counters. Optional payload toggle accumulation for switching
// activity figures is built only when FLIT_SINK_TOGGLE_EN is defined;
// otherwise toggle_acc is tied to zero.
module flit_sink #(
  parameter int DATAW = 66,
  parameter int VCHW  = 2,
  parameter int LENW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DATAW-1:0] idata,
  input  logic             ivalid,
  input  logic [VCHW-1:0]  ivch,
  output logic             pkt_done,
  output logic [LENW-1:0]  last_len,
  output logic [VCHW-1:0]  last_vch,
  output logic [31:0]      pkt_cnt,
  output logic [31:0]      flit_cnt,
  output logic [15:0]      err_cnt,
  output logic [31:0]      toggle_acc
);

  localparam int PAYW = DATAW - 2;

  localparam logic [1:0] TYP_NONE = 2'b00;
  localparam logic [1:0] TYP_HEAD = 2'b01;
  localparam logic [1:0] TYP_DATA = 2'b10;
  localparam logic [1:0] TYP_TAIL = 2'b11;

  localparam logic [LENW-1:0] LEN_ZERO = {LENW{1'b0}};
  localparam logic [LENW-1:0] LEN_ONE  = {{(LENW-1){1'b0}}, 1'b1};
  localparam logic [LENW-1:0] LEN_MAX  = {LENW{1'b1}};
  localparam logic [VCHW-1:0] VCH_ZERO = {VCHW{1'b0}};
  localparam logic [15:0]     ERR_MAX  = 16'hFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [1:0]      typ_s;
  logic            accept_s;
  logic            vch_mis_s;
  logic            err_s;
  logic            done_s;
  logic            restart_s;
  logic            len_inc_s;

  logic [LENW-1:0] len_q, len_d;
  logic [VCHW-1:0] cur_vch_q, cur_vch_d;
  logic [LENW-1:0] last_len_q, last_len_d;
  logic [VCHW-1:0] last_vch_q, last_vch_d;
  logic            pkt_done_q, pkt_done_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
  logic [31:0]     flit_cnt_q, flit_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  assign typ_s     = idata[DATAW-1:DATAW-2];
  // A flit arriving together with clr is discarded entirely.
  assign accept_s  = ivalid & ~clr;
  assign vch_mis_s = (state_q == ST_BODY) && (ivch != cur_vch_q);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (ivalid) begin
      case (state_q)
        ST_IDLE: begin
          if (typ_s == TYP_HEAD) begin
            state_d = ST_BODY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BODY: begin
          case (typ_s)
            TYP_HEAD: state_d = ST_BODY;
            TYP_DATA: state_d = ST_BODY;
            TYP_TAIL: state_d = ST_IDLE;
            TYP_NONE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM output decode: per-flit framing decisions
  always_comb begin
    err_s     = 1'b0;
    done_s    = 1'b0;
    restart_s = 1'b0;
    len_inc_s = 1'b0;
    if (accept_s) begin
      case (state_q)
        ST_IDLE: begin
          if (typ_s == TYP_HEAD) begin
            restart_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end
        ST_BODY: begin
          // A VC mismatch is a single error; the type is still acted upon,
          // except that a mismatched TAIL does not complete the packet.
          err_s = vch_mis_s;
          case (typ_s)
            TYP_HEAD: begin
              err_s     = 1'b1;
              restart_s = 1'b1;
            end
            TYP_DATA: len_inc_s = 1'b1;
            TYP_TAIL: done_s    = ~vch_mis_s;
            TYP_NONE: err_s     = 1'b1;
            default:  err_s     = 1'b1;
          endcase
        end
        default: err_s = 1'b0;
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // Datapath next-state: packet length, VC tracking and counters
  always_comb begin
    len_d      = len_q;
    cur_vch_d  = cur_vch_q;
    last_len_d = last_len_q;
    last_vch_d = last_vch_q;
    pkt_done_d = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    flit_cnt_d = flit_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clr) begin
      len_d      = LEN_ZERO;
      cur_vch_d  = VCH_ZERO;
      last_len_d = LEN_ZERO;
      last_vch_d = VCH_ZERO;
      pkt_cnt_d  = 32'd0;
      flit_cnt_d = 32'd0;
      err_cnt_d  = 16'd0;
    end else if (ivalid) begin
      flit_cnt_d = flit_cnt_q + 32'd1;
      if (err_s && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (restart_s) begin
        len_d     = LEN_ZERO;
        cur_vch_d = ivch;
      end else if (len_inc_s && (len_q != LEN_MAX)) begin
        len_d = len_q + LEN_ONE;
      end else begin
        len_d = len_q;
      end
      if (done_s) begin
        pkt_done_d = 1'b1;
        pkt_cnt_d  = pkt_cnt_q + 32'd1;
        last_len_d = len_q;
        last_vch_d = cur_vch_q;
      end else begin
        pkt_done_d = 1'b0;
      end
    end else begin
      pkt_done_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= LEN_ZERO;
      cur_vch_q  <= VCH_ZERO;
      last_len_q <= LEN_ZERO;
      last_vch_q <= VCH_ZERO;
      pkt_done_q <= 1'b0;
      pkt_cnt_q  <= 32'd0;
      flit_cnt_q <= 32'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      len_q      <= len_d;
      cur_vch_q  <= cur_vch_d;
      last_len_q <= last_len_d;
      last_vch_q <= last_vch_d;
      pkt_done_q <= pkt_done_d;
      pkt_cnt_q  <= pkt_cnt_d;
      flit_cnt_q <= flit_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign pkt_done = pkt_done_q;
  assign last_len = last_len_q;
  assign last_vch = last_vch_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign flit_cnt = flit_cnt_q;
  assign err_cnt  = err_cnt_q;

`ifdef FLIT_SINK_TOGGLE_EN

  // Number of set bits in a payload word.
  function automatic logic [31:0] popcount(input logic [PAYW-1:0] v);
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < PAYW; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

  logic [PAYW-1:0] prev_q, prev_d;
  logic            have_prev_q, have_prev_d;
  logic [31:0]     tog_q, tog_d;
  logic [32:0]     tog_sum_s;

  assign tog_sum_s = {1'b0, tog_q} + {1'b0, popcount(idata[PAYW-1:0] ^ prev_q)};

  // Toggle accumulator next-state: Hamming distance to previous payload
  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    tog_d       = tog_q;
    if (clr) begin
      prev_d      = {PAYW{1'b0}};
      have_prev_d = 1'b0;
      tog_d       = 32'd0;
    end else if (ivalid) begin
      prev_d      = idata[PAYW-1:0];
      have_prev_d = 1'b1;
      if (have_prev_q) begin
        tog_d = tog_sum_s[32] ? 32'hFFFF_FFFF : tog_sum_s[31:0];
      end else begin
        tog_d = tog_q;
      end
    end else begin
      tog_d = tog_q;
    end
  end

  // Toggle accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= {PAYW{1'b0}};
      have_prev_q <= 1'b0;
      tog_q       <= 32'd0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      tog_q       <= tog_d;
    end
  end

  assign toggle_acc = tog_q;

`else

  // Payload bits only feed the toggle logic, which is not built here.
  logic unused_payload_s;
  assign unused_payload_s = ^idata[PAYW-1:0];
  assign toggle_acc       = 32'h0000_0000;

`endif

endmodule

// File: tb/tb_flit_sink.sv
// Directed self-checking bench for flit_sink (default parameters).
// Toggle expectations follow FLIT_SINK_TOGGLE_EN.
module tb_flit_sink;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

`ifdef FLIT_SINK_TOGGLE_EN
  localparam logic [31:0] EXP_TOG = 32'd124;
`else
  localparam logic [31:0] EXP_TOG = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic        clr;
  logic [65:0] idata;
  logic        ivalid;
  logic [1:0]  ivch;
  logic        pkt_done;
  logic [7:0]  last_len;
  logic [1:0]  last_vch;
  logic [31:0] pkt_cnt;
  logic [31:0] flit_cnt;
  logic [15:0] err_cnt;
  logic [31:0] toggle_acc;

  int total_q;
  int bad_q;

  flit_sink dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .idata      (idata),
    .ivalid     (ivalid),
    .ivch       (ivch),
    .pkt_done   (pkt_done),
    .last_len   (last_len),
    .last_vch   (last_vch),
    .pkt_cnt    (pkt_cnt),
    .flit_cnt   (flit_cnt),
    .err_cnt    (err_cnt),
    .toggle_acc (toggle_acc)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_q++;
    if (obs !== exp) begin
      bad_q++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic flit(input logic [1:0] t, input logic [1:0] v, input logic [63:0] p);
    @(negedge clk);
    rst    = 1'b0;
    clr    = 1'b0;
    ivalid = 1'b1;
    idata  = {t, p};
    ivch   = v;
  endtask

  task automatic idle();
    @(negedge clk);
    rst    = 1'b0;
    clr    = 1'b0;
    ivalid = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr    = 1'b1;
    ivalid = 1'b0;
    idle();
  endtask

  // Directed sequence
  initial begin
    total_q = 0;
    bad_q   = 0;
    rst     = 1'b1;
    clr     = 1'b0;
    ivalid  = 1'b0;
    idata   = 66'd0;
    ivch    = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_done",   {31'd0, pkt_done}, 32'd0);
    chk("rst_len",    {24'd0, last_len}, 32'd0);
    chk("rst_vch",    {30'd0, last_vch}, 32'd0);
    chk("rst_pkt",    pkt_cnt, 32'd0);
    chk("rst_flit",   flit_cnt, 32'd0);
    chk("rst_err",    {16'd0, err_cnt}, 32'd0);
    chk("rst_tog",    toggle_acc, 32'd0);

    // Single packet on VC 1 with 20 data flits
    flit(T_HEAD, 2'd1, 64'd0);
    for (int i = 0; i < 20; i++) flit(T_DATA, 2'd1, 64'(i));
    flit(T_TAIL, 2'd1, 64'd0);
    idle();
    chk("p1_done",  {31'd0, pkt_done}, 32'd1);
    chk("p1_len",   {24'd0, last_len}, 32'd20);
    chk("p1_vch",   {30'd0, last_vch}, 32'd1);
    chk("p1_pkt",   pkt_cnt, 32'd1);
    chk("p1_flit",  flit_cnt, 32'd22);
    chk("p1_err",   {16'd0, err_cnt}, 32'd0);
    idle();
    chk("p1_done_low", {31'd0, pkt_done}, 32'd0);

    // Ten packets separated by idle gaps
    do_clr();
    for (int k = 0; k < 10; k++) begin
      flit(T_HEAD, 2'(k), 64'd0);
      for (int i = 0; i < 20; i++) flit(T_DATA, 2'(k), 64'(k * 100 + i));
      flit(T_TAIL, 2'(k), 64'd0);
      repeat (7) idle();
    end
    chk("m_pkt",  pkt_cnt, 32'd10);
    chk("m_flit", flit_cnt, 32'd220);
    chk("m_err",  {16'd0, err_cnt}, 32'd0);
    chk("m_len",  {24'd0, last_len}, 32'd20);
    chk("m_vch",  {30'd0, last_vch}, 32'd1);

    // DATA in IDLE, then HEAD, HEAD (restart), TAIL
    do_clr();
    flit(T_DATA, 2'd0, 64'd0);
    flit(T_HEAD, 2'd0, 64'd0);
    flit(T_HEAD, 2'd0, 64'd0);
    flit(T_TAIL, 2'd0, 64'd0);
    idle();
    chk("f_done", {31'd0, pkt_done}, 32'd1);
    chk("f_err",  {16'd0, err_cnt}, 32'd2);
    chk("f_pkt",  pkt_cnt, 32'd1);
    chk("f_len",  {24'd0, last_len}, 32'd0);
    // HEAD on VC 0 closed by TAIL on VC 2
    flit(T_HEAD, 2'd0, 64'd0);
    flit(T_TAIL, 2'd2, 64'd0);
    idle();
    chk("v_done", {31'd0, pkt_done}, 32'd0);
    chk("v_err",  {16'd0, err_cnt}, 32'd3);
    chk("v_pkt",  pkt_cnt, 32'd1);
    chk("v_flit", flit_cnt, 32'd6);
    // Mismatched DATA still counts toward length; packet still completes
    flit(T_HEAD, 2'd1, 64'd0);
    flit(T_DATA, 2'd3, 64'd0);
    flit(T_TAIL, 2'd1, 64'd0);
    idle();
    chk("d_done", {31'd0, pkt_done}, 32'd1);
    chk("d_err",  {16'd0, err_cnt}, 32'd4);
    chk("d_len",  {24'd0, last_len}, 32'd1);
    // NONE mid-packet abandons it; following TAIL is an IDLE error
    flit(T_HEAD, 2'd0, 64'd0);
    flit(T_NONE, 2'd0, 64'd0);
    flit(T_TAIL, 2'd0, 64'd0);
    idle();
    chk("n_done", {31'd0, pkt_done}, 32'd0);
    chk("n_err",  {16'd0, err_cnt}, 32'd6);
    chk("n_pkt",  pkt_cnt, 32'd2);
    // Back-to-back TAIL then TAIL
    flit(T_HEAD, 2'd2, 64'd0);
    flit(T_TAIL, 2'd2, 64'd0);
    flit(T_TAIL, 2'd2, 64'd0);
    idle();
    chk("tt_err", {16'd0, err_cnt}, 32'd7);
    chk("tt_pkt", pkt_cnt, 32'd3);
    chk("tt_vch", {30'd0, last_vch}, 32'd2);

    // Length saturation
    do_clr();
    flit(T_HEAD, 2'd3, 64'd0);
    for (int i = 0; i < 300; i++) flit(T_DATA, 2'd3, 64'd0);
    flit(T_TAIL, 2'd3, 64'd0);
    idle();
    chk("s_len",  {24'd0, last_len}, 32'd255);
    chk("s_flit", flit_cnt, 32'd302);
    chk("s_err",  {16'd0, err_cnt}, 32'd0);

    // Payload toggles
    do_clr();
    chk("t_clr", toggle_acc, 32'd0);
    flit(T_HEAD, 2'd0, 64'h0);
    flit(T_DATA, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    flit(T_DATA, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    flit(T_TAIL, 2'd0, 64'hF);
    idle();
    chk("t_acc", toggle_acc, EXP_TOG);
    chk("t_len", {24'd0, last_len}, 32'd2);

    // Reset mid-packet drops the packet without an error
    flit(T_HEAD, 2'd1, 64'd0);
    flit(T_DATA, 2'd1, 64'd0);
    @(negedge clk);
    rst    = 1'b1;
    ivalid = 1'b0;
    flit(T_TAIL, 2'd1, 64'd0);
    idle();
    chk("r_err",  {16'd0, err_cnt}, 32'd1);
    chk("r_pkt",  pkt_cnt, 32'd0);
    chk("r_flit", flit_cnt, 32'd1);
    chk("r_tog",  toggle_acc, 32'd0);

    // clr together with TAIL mid-packet
    do_clr();
    flit(T_HEAD, 2'd0, 64'h5);
    flit(T_DATA, 2'd0, 64'hA);
    @(negedge clk);
    clr    = 1'b1;
    ivalid = 1'b1;
    idata  = {T_TAIL, 64'h0};
    ivch   = 2'd0;
    idle();
    chk("c_done", {31'd0, pkt_done}, 32'd0);
    chk("c_pkt",  pkt_cnt, 32'd0);
    chk("c_flit", flit_cnt, 32'd0);
    chk("c_err",  {16'd0, err_cnt}, 32'd0);
    chk("c_len",  {24'd0, last_len}, 32'd0);
    chk("c_tog",  toggle_acc, 32'd0);
    flit(T_HEAD, 2'd2, 64'd0);
    flit(T_DATA, 2'd2, 64'd0);
    flit(T_TAIL, 2'd2, 64'd0);
    idle();
    chk("c2_done", {31'd0, pkt_done}, 32'd1);
    chk("c2_len",  {24'd0, last_len}, 32'd1);
    chk("c2_pkt",  pkt_cnt, 32'd1);
    chk("c2_flit", flit_cnt, 32'd3);
    chk("c2_err",  {16'd0, err_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_q, bad_q);
    $finish;
  end

endmodule
